// File: rtl/kNN_pkg.sv
// Shared definitions for the kNN transmit-side datapath.
//   state_t    : feeder FSM encoding
//   DATA_WIDTH : default dimension value width
//   MAX_DIMS   : default query register file depth
package kNN_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DATA_WIDTH = 32;
    localparam int MAX_DIMS   = 64;

endpackage

// File: rtl/knn_query_regfile.sv
// Query vector storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a query survives a datapath reset.
//   clk       : system clock
//   wr_en     : write strobe
//   wr_addr   : write index (indices >= maxDims are dropped)
//   wr_data   : write value
//   rd_addr   : read index
//   rd_data   : combinational read value
module knn_query_regfile #(
    parameter int dataWidth    = 32,
    parameter int maxDims      = 64,
    parameter int dimAddrWidth = 6
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [dimAddrWidth-1:0] wr_addr,
    input  logic [dataWidth-1:0]    wr_data,
    input  logic [dimAddrWidth-1:0] rd_addr,
    output logic [dataWidth-1:0]    rd_data
);

    logic [dataWidth-1:0] mem [maxDims];
    logic                 wr_ok;

    // The range guard only exists when the index space exceeds the storage.
    generate
        if ((2 ** dimAddrWidth) > maxDims) begin : g_guard
            assign wr_ok = wr_en && (int'(wr_addr) < maxDims);
        end else begin : g_noguard
            assign wr_ok = wr_en;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/knn_stream_feeder.sv
// Streams dataset points from an external synchronous BRAM one dimension per
// cycle, with the matching query dimension alongside, into the kNN core.
//   clk, reset            : clock, synchronous active-high reset
//   start                 : run request pulse (ignored unless idle)
//   numberOfDimensions/Points, baseAddr : run geometry, sampled on start
//   hold                  : stalls read issue
//   queryWr*              : query register file write port (blocked while busy)
//   memAddr/memRdEn/memData : dataset BRAM port, 1-cycle read latency
//   refDataOut, dataValueOut, dataNameOut, loadRef, lastDim, valid : output beat
//   busy, done, error     : run status
module knn_stream_feeder
    import kNN_pkg::*;
#(
    parameter int dataWidth    = DATA_WIDTH,
    parameter int addrWidth    = 16,
    parameter int maxDims      = MAX_DIMS,
    parameter int dimAddrWidth = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [31:0]             numberOfDimensions,
    input  logic [31:0]             numberOfPoints,
    input  logic [addrWidth-1:0]    baseAddr,
    input  logic                    hold,
    input  logic                    queryWrEn,
    input  logic [dimAddrWidth-1:0] queryWrAddr,
    input  logic [dataWidth-1:0]    queryDataIn,
    output logic [addrWidth-1:0]    memAddr,
    output logic                    memRdEn,
    input  logic [dataWidth-1:0]    memData,
    output logic [dataWidth-1:0]    refDataOut,
    output logic [dataWidth-1:0]    dataValueOut,
    output logic [31:0]             dataNameOut,
    output logic                    loadRef,
    output logic                    lastDim,
    output logic                    valid,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam logic [31:0] MAX_D = 32'(maxDims);

    state_t                  state, state_nx;
    logic [31:0]             num_dims, num_pts;
    logic [31:0]             dim_cnt, pt_cnt;
    logic [addrWidth-1:0]    addr_cnt;
    logic                    issue, dim_wrap, last_issue, reject;

    // Beat registers: everything captured at issue, shown one cycle later
    // alongside the BRAM read data.
    logic                    beat_vld, beat_load, beat_last;
    logic [dimAddrWidth-1:0] beat_dim;
    logic [31:0]             beat_pt;
    logic [dataWidth-1:0]    query_rd;

    assign issue      = (state == ST_STREAM) && !hold;
    assign dim_wrap   = (dim_cnt == num_dims - 32'd1);
    assign last_issue = issue && dim_wrap && (pt_cnt == num_pts - 32'd1);
    assign reject     = (numberOfDimensions == 32'd0) || (numberOfPoints == 32'd0) ||
                        (numberOfDimensions > MAX_D);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (start) state_nx = reject ? ST_DONE : ST_STREAM;
            ST_STREAM: if (last_issue) state_nx = ST_FLUSH;
            ST_FLUSH:  state_nx = ST_DONE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            num_dims  <= '0;
            num_pts   <= '0;
            dim_cnt   <= '0;
            pt_cnt    <= '0;
            addr_cnt  <= '0;
            error     <= 1'b0;
            beat_vld  <= 1'b0;
            beat_load <= 1'b0;
            beat_last <= 1'b0;
            beat_dim  <= '0;
            beat_pt   <= '0;
        end else begin
            state    <= state_nx;
            beat_vld <= issue;
            if (state == ST_IDLE && start) begin
                num_dims <= numberOfDimensions;
                num_pts  <= numberOfPoints;
                dim_cnt  <= '0;
                pt_cnt   <= '0;
                addr_cnt <= baseAddr;
                error    <= numberOfDimensions > MAX_D;
            end else if (issue) begin
                beat_dim  <= dim_cnt[dimAddrWidth-1:0];
                beat_pt   <= pt_cnt;
                beat_load <= (dim_cnt == 32'd0);
                beat_last <= dim_wrap;
                addr_cnt  <= addr_cnt + 1'b1;  // wraps naturally at 2^addrWidth
                if (dim_wrap) begin
                    dim_cnt <= '0;
                    pt_cnt  <= pt_cnt + 32'd1;
                end else begin
                    dim_cnt <= dim_cnt + 32'd1;
                end
            end
        end
    end

    knn_query_regfile #(
        .dataWidth    (dataWidth),
        .maxDims      (maxDims),
        .dimAddrWidth (dimAddrWidth)
    ) u_query (
        .clk     (clk),
        .wr_en   (queryWrEn && !busy),
        .wr_addr (queryWrAddr),
        .wr_data (queryDataIn),
        .rd_addr (beat_dim),
        .rd_data (query_rd)
    );

    assign memRdEn      = issue;
    assign memAddr      = issue ? addr_cnt : '0;
    assign valid        = beat_vld;
    // Gate beat fields so idle cycles show zeros rather than stale memory data.
    assign dataValueOut = beat_vld ? memData  : '0;
    assign refDataOut   = beat_vld ? query_rd : '0;
    assign dataNameOut  = beat_vld ? beat_pt  : '0;
    assign loadRef      = beat_vld && beat_load;
    assign lastDim      = beat_vld && beat_last;
    assign busy         = (state == ST_STREAM) || (state == ST_FLUSH);
    assign done         = (state == ST_DONE);

endmodule

// File: tb/tb_knn_stream_feeder.sv
module tb_knn_stream_feeder;

    logic        clk, reset, start, hold, queryWrEn;
    logic [31:0] numberOfDimensions, numberOfPoints;
    logic [15:0] baseAddr, memAddr;
    logic [5:0]  queryWrAddr;
    logic [31:0] queryDataIn, memData, refDataOut, dataValueOut, dataNameOut;
    logic        memRdEn, loadRef, lastDim, valid, busy, done, error;

    knn_stream_feeder dut (
        .clk(clk), .reset(reset), .start(start),
        .numberOfDimensions(numberOfDimensions), .numberOfPoints(numberOfPoints),
        .baseAddr(baseAddr), .hold(hold), .queryWrEn(queryWrEn),
        .queryWrAddr(queryWrAddr), .queryDataIn(queryDataIn),
        .memAddr(memAddr), .memRdEn(memRdEn), .memData(memData),
        .refDataOut(refDataOut), .dataValueOut(dataValueOut), .dataNameOut(dataNameOut),
        .loadRef(loadRef), .lastDim(lastDim), .valid(valid), .busy(busy),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Synchronous BRAM model: one-cycle latency, holds data when not read.
    logic [31:0] mem [0:65535];
    always @(posedge clk) if (memRdEn) memData <= mem[memAddr];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Captured results of the last run.
    int          nb, rd_cnt, done_cyc;
    logic [31:0] bv [16], br [16], bn [16];
    logic        blr [16], bld [16];
    int          bc [16];
    logic [15:0] ra [16];
    logic [31:0] rden_mask;

    // Cycle 0 is the start cycle; cycle c is sampled 2ns after the c-th edge.
    task automatic run(input logic [31:0] d, input logic [31:0] p, input logic [15:0] base,
                       input int h_lo, input int h_hi, input int s_a, input int s_b,
                       input int wr_c, input int maxc);
        nb = 0; rd_cnt = 0; done_cyc = -1; rden_mask = '0;
        numberOfDimensions = d; numberOfPoints = p; baseAddr = base; start = 1'b1;
        for (int c = 1; c <= maxc && done_cyc < 0; c++) begin
            @(posedge clk); #1;
            start = (c == s_a) || (c == s_b);
            numberOfDimensions = 32'd1;  // shows the run geometry was latched
            numberOfPoints     = 32'd1;
            baseAddr           = 16'h0000;
            hold        = (c >= h_lo) && (c <= h_hi);
            queryWrEn   = (c == wr_c);
            queryWrAddr = 6'd0;
            queryDataIn = 32'd999;
            #1;
            if (memRdEn) begin
                rden_mask[c] = 1'b1;
                if (rd_cnt < 16) ra[rd_cnt] = memAddr;
                rd_cnt++;
            end
            if (valid) begin
                if (nb < 16) begin
                    bv[nb] = dataValueOut; br[nb] = refDataOut; bn[nb] = dataNameOut;
                    blr[nb] = loadRef; bld[nb] = lastDim; bc[nb] = c;
                end
                nb++;
            end
            if (done) done_cyc = c;
        end
        chk("done_seen", (done_cyc >= 0) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk); #1;
        start = 1'b0; hold = 1'b0; queryWrEn = 1'b0;
        #1;
        chk("post_busy", {31'd0, busy}, 32'd0);
        chk("post_rden", {31'd0, memRdEn}, 32'd0);
    endtask

    // Reference run: query {10,20,30}, memory 1..6 at 0x0100, D=3, P=2.
    task automatic check_std(input string tag, input int exp_done, input int c0, input int c1,
                             input int c2, input int c3, input int c4, input int c5);
        int ev [6] = '{1, 2, 3, 4, 5, 6};
        int er [6] = '{10, 20, 30, 10, 20, 30};
        int en [6] = '{0, 0, 0, 1, 1, 1};
        int el [6] = '{1, 0, 0, 1, 0, 0};
        int ed [6] = '{0, 0, 1, 0, 0, 1};
        int ec [6];
        ec = '{c0, c1, c2, c3, c4, c5};
        chk({tag, "_nbeats"}, nb, 6);
        chk({tag, "_done"}, done_cyc, exp_done);
        chk({tag, "_reads"}, rd_cnt, 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s_val%0d", tag, i), bv[i], ev[i]);
            chk($sformatf("%s_ref%0d", tag, i), br[i], er[i]);
            chk($sformatf("%s_name%0d", tag, i), bn[i], en[i]);
            chk($sformatf("%s_lr%0d", tag, i), {31'd0, blr[i]}, el[i]);
            chk($sformatf("%s_ld%0d", tag, i), {31'd0, bld[i]}, ed[i]);
            chk($sformatf("%s_cyc%0d", tag, i), bc[i], ec[i]);
        end
        for (int i = 0; i < 6; i++) chk($sformatf("%s_addr%0d", tag, i), {16'd0, ra[i]}, 32'h100 + i);
    endtask

    initial begin
        logic saw_done;
        clk = 0; reset = 1; start = 0; hold = 0; queryWrEn = 0;
        numberOfDimensions = 0; numberOfPoints = 0; baseAddr = 0;
        queryWrAddr = 0; queryDataIn = 0; memData = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 32'h1000_0000 | i;
        for (int i = 0; i < 6; i++) mem[16'h100 + i] = i + 1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_busy",  {31'd0, busy}, 0);
        chk("rst_done",  {31'd0, done}, 0);
        chk("rst_error", {31'd0, error}, 0);
        chk("rst_rden",  {31'd0, memRdEn}, 0);
        chk("rst_data",  dataValueOut, 0);
        reset = 0;

        // Load query {10,20,30}
        for (int i = 0; i < 3; i++) begin
            queryWrEn = 1; queryWrAddr = 6'(i); queryDataIn = 32'(10 * (i + 1));
            @(posedge clk); #1;
        end
        queryWrEn = 0;

        // Basic run
        run(3, 2, 16'h0100, -1, -1, -1, -1, -1, 20);
        check_std("t1", 8, 2, 3, 4, 5, 6, 7);
        chk("t1_err", {31'd0, error}, 0);

        // Hold during cycles 3-4: one in-flight beat, done 2 cycles late
        run(3, 2, 16'h0100, 3, 4, -1, -1, -1, 20);
        check_std("hold", 10, 2, 3, 6, 7, 8, 9);
        chk("hold_rden", rden_mask, 32'h0000_01E6);

        // Rejected runs
        run(0, 5, 16'h0100, -1, -1, -1, -1, -1, 10);
        chk("d0_done", done_cyc, 1);
        chk("d0_reads", rd_cnt, 0);
        chk("d0_beats", nb, 0);
        chk("d0_err", {31'd0, error}, 0);
        run(65, 2, 16'h0100, -1, -1, -1, -1, -1, 10);
        chk("d65_done", done_cyc, 1);
        chk("d65_reads", rd_cnt, 0);
        chk("d65_err", {31'd0, error}, 1);
        run(3, 2, 16'h0100, -1, -1, -1, -1, -1, 20);
        check_std("clr", 8, 2, 3, 4, 5, 6, 7);
        chk("clr_err", {31'd0, error}, 0);

        // Address wrap
        run(2, 1, 16'hFFFF, -1, -1, -1, -1, -1, 10);
        chk("wrap_a0", {16'd0, ra[0]}, 32'h0000_FFFF);
        chk("wrap_a1", {16'd0, ra[1]}, 32'h0000_0000);
        chk("wrap_v0", bv[0], 32'h1000_FFFF);
        chk("wrap_v1", bv[1], 32'h1000_0000);
        chk("wrap_r1", br[1], 20);
        chk("wrap_done", done_cyc, 4);

        // Reset during beat 3
        numberOfDimensions = 3; numberOfPoints = 2; baseAddr = 16'h0100; start = 1;
        @(posedge clk); #1; start = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("mid_beat3", dataValueOut, 3);
        chk("mid_v3", {31'd0, valid}, 1);
        reset = 1;
        @(posedge clk); #2;
        chk("mid_valid", {31'd0, valid}, 0);
        chk("mid_busy", {31'd0, busy}, 0);
        chk("mid_rden", {31'd0, memRdEn}, 0);
        saw_done = done;
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            saw_done = saw_done | done;
        end
        chk("mid_nodone", {31'd0, saw_done}, 0);
        run(3, 2, 16'h0100, -1, -1, -1, -1, -1, 20);
        check_std("replay", 8, 2, 3, 4, 5, 6, 7);

        // Start while busy (STREAM and DONE) and query write while busy
        run(3, 2, 16'h0100, -1, -1, 3, 8, 3, 20);
        check_std("inj", 8, 2, 3, 4, 5, 6, 7);
        run(3, 2, 16'h0100, -1, -1, -1, -1, -1, 20);
        check_std("after", 8, 2, 3, 4, 5, 6, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
